// File: rtl/divclk_sequencer.sv
// divclk_sequencer: run/stop controller around a 50%-duty programmable clock divider.
// New half-periods are staged in a shadow register and applied only at period boundaries.
module divclk_sequencer #(
    parameter int WIDTH     = 32,
    parameter int N_DEFAULT = 1,
    parameter int BURST_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    input  logic [WIDTH-1:0]   cfg_half,
    output logic               cfg_ready,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    output logic               out,
    output logic               rise_pulse,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] period_cnt
);
    localparam logic [WIDTH-1:0] N_RST = WIDTH'(N_DEFAULT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t             state;
    logic [WIDTH-1:0]   cnt;
    logic [WIDTH-1:0]   active_n;
    logic [WIDTH-1:0]   shadow_n;
    logic [WIDTH-1:0]   cfg_n;
    logic [BURST_W-1:0] target;
    logic [BURST_W-1:0] pc_next;
    logic               pending;
    logic               stop_pend;
    logic               accept;
    logic               half_end;
    logic               finish;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & ~pending;
    assign cfg_n     = (cfg_half == '0) ? WIDTH'(1) : cfg_half;
    // active_n is never 0, so the subtraction cannot wrap
    assign half_end  = cnt == active_n - WIDTH'(1);
    assign pc_next   = (&period_cnt) ? period_cnt : period_cnt + BURST_W'(1);
    assign finish    = stop_pend | ((target != '0) && (pc_next == target));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            active_n   <= N_RST;
            shadow_n   <= N_RST;
            target     <= '0;
            pending    <= 1'b0;
            stop_pend  <= 1'b0;
            out        <= 1'b0;
            rise_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            period_cnt <= '0;
        end else begin
            rise_pulse <= 1'b0;
            done       <= 1'b0;
            if (accept)
                shadow_n <= cfg_n;
            case (state)
                IDLE: begin
                    if (accept)
                        active_n <= cfg_n;
                    if (start && !stop) begin
                        state      <= HIGH;
                        out        <= 1'b1;
                        rise_pulse <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        target     <= burst_len;
                        period_cnt <= '0;
                    end
                end
                HIGH: begin
                    if (accept)
                        pending <= 1'b1;
                    if (stop)
                        stop_pend <= 1'b1;
                    if (half_end) begin
                        state <= LOW;
                        out   <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                LOW: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (!half_end) begin
                        cnt <= cnt + WIDTH'(1);
                        if (accept)
                            pending <= 1'b1;
                    end else begin
                        // period boundary: a value accepted on this very edge waits for the next one
                        cnt        <= '0;
                        period_cnt <= pc_next;
                        pending    <= accept;
                        if (pending)
                            active_n <= shadow_n;
                        if (finish) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stop_pend <= 1'b0;
                        end else begin
                            state      <= HIGH;
                            out        <= 1'b1;
                            rise_pulse <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divclk_sequencer.sv
// tb_divclk_sequencer: directed bench for divclk_sequencer with hand-derived cycle patterns.
module tb_divclk_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [31:0] cfg_half;
    logic        cfg_ready;
    logic        start;
    logic        stop;
    logic [15:0] burst_len;
    logic        out;
    logic        rise_pulse;
    logic        busy;
    logic        done;
    logic [15:0] period_cnt;
    int          tests = 0;
    int          fails = 0;
    int          dones;

    divclk_sequencer #(.WIDTH(32), .N_DEFAULT(1), .BURST_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_half(cfg_half),
        .cfg_ready(cfg_ready), .start(start), .stop(stop), .burst_len(burst_len),
        .out(out), .rise_pulse(rise_pulse), .busy(busy), .done(done),
        .period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; cfg_valid = 1'b0; cfg_half = '0; start = 1'b0; stop = 1'b0; burst_len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_pcnt", period_cnt, 0);
        chk("rst_ready", cfg_ready, 1);
        reset = 1'b1;
        tick();

        // burst of 2 periods at N=3
        cfg_valid = 1'b1; cfg_half = 3; tick(); cfg_valid = 1'b0;
        chk("t1_ready", cfg_ready, 1);
        start = 1'b1; burst_len = 2; tick(); start = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            chk($sformatf("t1_out%0d", i), out, (i <= 3 || (i >= 7 && i <= 9)) ? 1 : 0);
            chk($sformatf("t1_rise%0d", i), rise_pulse, (i == 1 || i == 7) ? 1 : 0);
            chk($sformatf("t1_done%0d", i), done, (i == 13) ? 1 : 0);
            chk($sformatf("t1_busy%0d", i), busy, (i <= 12) ? 1 : 0);
            if (i < 13) tick();
        end
        chk("t1_pcnt", period_cnt, 2);
        tick();

        // continuous at N=2, stop during period 2
        cfg_valid = 1'b1; cfg_half = 2; tick(); cfg_valid = 1'b0;
        start = 1'b1; burst_len = 0; tick(); start = 1'b0;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("t2_out%0d", i), out, (i == 1 || i == 2 || i == 5 || i == 6) ? 1 : 0);
            chk($sformatf("t2_busy%0d", i), busy, (i <= 8) ? 1 : 0);
            if (i == 9) chk("t2_done9", done, 1);
            dones += int'(done);
            stop = (i == 5);
            tick();
        end
        stop = 1'b0;
        chk("t2_done_once", dones, 1);
        chk("t2_pcnt", period_cnt, 2);

        // N=4 running, cfg_half=1 accepted mid-HIGH
        cfg_valid = 1'b1; cfg_half = 4; tick(); cfg_valid = 1'b0;
        start = 1'b1; burst_len = 0; tick(); start = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            chk($sformatf("t3_out%0d", i), out, (i <= 4 || i == 9 || i == 11) ? 1 : 0);
            chk($sformatf("t3_rise%0d", i), rise_pulse, (i == 1 || i == 9 || i == 11) ? 1 : 0);
            chk($sformatf("t3_ready%0d", i), cfg_ready, (i <= 2 || i >= 9) ? 1 : 0);
            chk($sformatf("t3_done%0d", i), done, (i == 13) ? 1 : 0);
            cfg_valid = (i == 2); cfg_half = 1;
            stop = (i == 11);
            tick();
        end
        cfg_valid = 1'b0; stop = 1'b0;

        // cfg_half=0 behaves as N=1
        cfg_valid = 1'b1; cfg_half = 0; tick(); cfg_valid = 1'b0;
        start = 1'b1; burst_len = 2; tick(); start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("t4_out%0d", i), out, (i == 1 || i == 3) ? 1 : 0);
            chk($sformatf("t4_done%0d", i), done, (i == 5) ? 1 : 0);
            if (i < 5) tick();
        end
        chk("t4_pcnt", period_cnt, 2);
        tick();

        // start+stop together stays idle; lone stop in idle leaves no pending stop
        start = 1'b1; stop = 1'b1; burst_len = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("t5_busy%0d", i), busy, 0);
            chk($sformatf("t5_rise%0d", i), rise_pulse, 0);
            chk($sformatf("t5_out%0d", i), out, 0);
        end
        start = 1'b0; tick(); stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t5_run_busy%0d", i), busy, 1);
            chk($sformatf("t5_run_out%0d", i), out, i[0]);
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (4) tick();
        chk("t5_stopped", busy, 0);

        // async reset mid-LOW
        cfg_valid = 1'b1; cfg_half = 3; tick(); cfg_valid = 1'b0;
        start = 1'b1; burst_len = 0; tick(); start = 1'b0;
        repeat (10) tick();
        chk("t6_pre_out", out, 0);
        chk("t6_pre_busy", busy, 1);
        chk("t6_pre_pcnt", period_cnt, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_out", out, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_pcnt", period_cnt, 0);
        chk("t6_ready", cfg_ready, 1);
        @(negedge clk) reset = 1'b1;
        start = 1'b1; burst_len = 1; tick(); start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("t6_out%0d", i), out, (i == 1) ? 1 : 0);
            chk($sformatf("t6_done%0d", i), done, (i == 3) ? 1 : 0);
            if (i < 3) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
